div_iter: RTL and testbench
===========================

# div_iter

Iterative 32-bit signed/unsigned integer divider: the responder side of the EX-stage divide handshake. EX holds `start_i` high with stable operands while `ready_o` is low. The block computes one quotient bit per cycle and then presents `{remainder, quotient}` on `result_o` with `ready_o` high until EX drops `start_i`. Results feed the HI/LO write path: HI takes the remainder, LO takes the quotient.

## Interface
Parameters: none (width fixed at 32).

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start
- opdata1_i  in  32  dividend
- opdata2_i  in  32  divisor
- start_i  in  1  request; held high by EX until ready_o seen
- annul_i  in  1  abort current operation (EX ties to 0; still required)
- result_o  out  64  {remainder[63:32], quotient[31:0]}; valid only while ready_o = 1, else 0
- ready_o  out  1  result valid

## Operation
- States: IDLE, BYZERO, ON, END. Reset state is IDLE with result_o = 0 and ready_o = 0.
- **IDLE**
  - If start_i & ~annul_i and opdata2_i == 0: go to BYZERO.
  - If start_i & ~annul_i and opdata2_i != 0: go to ON, and latch:
    - signed_div_i;
    - sign of dividend and sign of divisor;
    - |opdata1_i| and |opdata2_i|. Two's-complement negate when signed and bit31 = 1; unsigned operands pass through.
  - Clear the iteration counter cnt (6 bits) and the 65-bit working register {partial_rem[31:0], dividend[31:0], 1'b0}.
  - Otherwise stay in IDLE.
- **ON, cnt != 32 (restoring iteration)**
  - Form the trial value: partial_rem shifted left 1 with the next dividend MSB shifted in, minus divisor (33-bit subtract).
  - Non-negative difference: partial_rem takes the difference and the quotient bit is 1.
  - Negative difference: partial_rem takes the shifted value and the quotient bit is 0.
  - Quotient bits enter LSB-first into the vacated dividend bits, so the MSB of the quotient is produced first. Increment cnt.
- **ON, cnt == 32 (sign fix-up)**
  - If signed and the operand signs differ, quotient := -quotient.
  - If signed and the dividend was negative, remainder := -remainder.
  - Load result_o, set ready_o = 1, go to END.
- **BYZERO**: next edge loads result_o = 0, ready_o = 1, goes to END. Divide-by-zero result is defined as all zeros.
- **END**
  - Hold result_o and ready_o while start_i = 1.
  - When start_i = 0: go to IDLE and clear result_o and ready_o to 0 on that edge.
- **annul_i = 1** in ON, BYZERO or END: go to IDLE next edge with result_o and ready_o = 0. No result is produced.
- Operand inputs are ignored after the IDLE sampling edge. Changes to them during ON do not affect the result.
- Arithmetic corner cases:
  - 0x80000000 / 0xFFFFFFFF (signed) gives quotient 0x80000000, remainder 0 (wraps, no trap).
  - |0x80000000| is treated as unsigned 0x80000000.
- rst has priority over every state and over annul_i. Mid-operation reset returns to IDLE with outputs 0 on the next edge.

## Timing
- Let edge E0 be the edge that samples start_i in IDLE.
- Nonzero divisor:
  - Iterations occur on edges E1..E32.
  - Fix-up occurs on E33.
  - ready_o = 1 from after E33 (33-cycle latency, EX stalled throughout).
- Zero divisor: ready_o = 1 from after E1.
- result_o and ready_o are registered outputs with no combinational path from inputs. EX's start_i may depend combinationally on ready_o; no loop results.
- EX drops start_i in the same cycle ready_o is seen high. The edge after that returns the block to IDLE.
- A new start_i asserted in the first IDLE cycle is accepted on that edge (back-to-back divides). Minimum spacing between ready pulses is 35 cycles.
- start_i still high on the edge leaving END never occurs, because END exits only on start_i = 0. Therefore no spurious restart.

## Test plan
- Unsigned 100 / 7, start held until ready: ready_o rises after E33, result_o = 0x00000002_0000000E. Next edge with start_i = 0 returns ready_o = 0 and result_o = 0.
- Signed -7 / 2 gives 0xFFFFFFFF_FFFFFFFD. Signed 7 / -2 gives 0x00000001_FFFFFFFD. Unsigned 0xFFFFFFF9 / 2 gives 0x00000001_7FFFFFFC.
- Signed 0x80000000 / 0xFFFFFFFF gives 0x00000000_80000000. Unsigned 0xFFFFFFFF / 0xFFFFFFFF gives 0x00000000_00000001.
- Divisor 0 (either mode): ready_o = 1 after E1, result_o = 0. The block must not enter ON.
- Abort cases:
  - annul_i pulsed at cnt = 10: IDLE next edge, ready_o never asserts.
  - rst asserted at cnt = 20: same behaviour.
  - A following 9 / 3 must return 0x00000000_00000003 with the full 33-cycle latency.
- Back-to-back: two divides issued with start re-asserted in the first IDLE cycle. The second divide's operands are changed during ON of the first. Both results are correct and the ready pulses are 35 cycles apart.

Source files
------------

// File: rtl/div_iter.sv
// div_iter: iterative 32-bit signed/unsigned restoring divider, one quotient bit per cycle.
module div_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);
    typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_t;
    state_t state, state_n;
    logic        sgn, neg1, neg2, go, ready_n;
    logic [5:0]  cnt;
    logic [31:0] rem, quo, dvs, q_fix, r_fix;
    logic [33:0] trial;
    logic [63:0] result_n;
    assign go = start_i & ~annul_i;
    // 34 bits so {rem, msb} up to 2*divisor never aliases the sign bit
    assign trial = {1'b0, rem, quo[31]} - {2'b0, dvs};
    assign q_fix = (sgn & (neg1 ^ neg2)) ? -quo : quo;
    assign r_fix = (sgn & neg1) ? -rem : rem;
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = go ? ((opdata2_i == '0) ? BYZERO : ON) : IDLE;
            BYZERO:  state_n = annul_i ? IDLE : END;
            ON:      state_n = annul_i ? IDLE : ((cnt == 6'd32) ? END : ON);
            END:     state_n = (annul_i | ~start_i) ? IDLE : END;
            default: state_n = IDLE;
        endcase
    end
    always_comb begin
        ready_n  = state_n == END;
        result_n = !ready_n ? '0 : (state == ON) ? {r_fix, q_fix} : (state == END) ? result_o : '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            sgn      <= 1'b0;
            neg1     <= 1'b0;
            neg2     <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            result_o <= result_n;
            ready_o  <= ready_n;
            if (state == IDLE) begin
                cnt  <= '0;
                rem  <= '0;
                sgn  <= signed_div_i;
                neg1 <= signed_div_i & opdata1_i[31];
                neg2 <= signed_div_i & opdata2_i[31];
                quo  <= (signed_div_i & opdata1_i[31]) ? -opdata1_i : opdata1_i;
                dvs  <= (signed_div_i & opdata2_i[31]) ? -opdata2_i : opdata2_i;
            end else if (state == ON && cnt != 6'd32) begin
                cnt <= cnt + 6'd1;
                rem <= trial[33] ? {rem[30:0], quo[31]} : trial[31:0];
                quo <= {quo[30:0], ~trial[33]};
            end
        end
    end
endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: directed and random divides checked against a plain-arithmetic reference.
module tb_div_iter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i = '0;
    logic [31:0] opdata2_i = '0;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [63:0] result_o;
    logic        ready_o;
    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_rise = 0;

    div_iter dut (
        .clk(clk), .rst(rst), .signed_div_i(signed_div_i),
        .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
        .start_i(start_i), .annul_i(annul_i),
        .result_o(result_o), .ready_o(ready_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
        longint x, y, q, r;
        if (b == 0) return 64'd0;
        x = s ? {{32{a[31]}}, a} : {32'd0, a};
        y = s ? {{32{b[31]}}, b} : {32'd0, b};
        q = x / y;
        r = x % y;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issues one divide from an IDLE cycle, scrambles operands after sampling, returns in the first IDLE cycle.
    task automatic run_div(input string tag, input bit s, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp;
        int n;
        bit quiet_bad;
        exp = ref_div(s, a, b);
        signed_div_i = s;
        opdata1_i = a;
        opdata2_i = b;
        start_i = 1'b1;
        n = 0;
        quiet_bad = 1'b0;
        do begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) begin
                opdata1_i = $urandom;
                opdata2_i = $urandom;
                signed_div_i = 1'($urandom);
            end
            if (!ready_o && result_o !== 64'd0) quiet_bad = 1'b1;
        end while (!ready_o && n < 100);
        last_rise = cyc;
        chk({tag, "_lat"}, 64'(n), (b == 0) ? 64'd2 : 64'd34);
        chk({tag, "_res"}, result_o, exp);
        chk({tag, "_quiet"}, 64'(quiet_bad), 64'd0);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        chk({tag, "_clr"}, {result_o, 63'd0, ready_o}, 127'd0);
    endtask

    task automatic run_abort(input string tag, input bit use_rst, input int at);
        bit seen;
        signed_div_i = 1'($urandom);
        opdata1_i = $urandom;
        opdata2_i = $urandom | 32'd1;
        start_i = 1'b1;
        seen = 1'b0;
        repeat (at + 1) begin
            @(posedge clk);
            #1;
            seen |= ready_o;
        end
        if (use_rst) rst = 1'b1;
        else annul_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        annul_i = 1'b0;
        chk({tag, "_out"}, {result_o, 63'd0, ready_o}, 127'd0);
        repeat (40) begin
            @(posedge clk);
            #1;
            seen |= ready_o;
        end
        chk({tag, "_noready"}, 64'(seen), 64'd0);
    endtask

    initial begin
        int r1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset", {result_o, 63'd0, ready_o}, 127'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        run_div("u100_7", 1'b0, 32'd100, 32'd7);
        chk("u100_7_exact", ref_div(1'b0, 32'd100, 32'd7), 64'h00000002_0000000E);
        r1 = last_rise;
        run_div("s_m7_2", 1'b1, -32'sd7, 32'd2);
        chk("b2b_spacing", 64'(last_rise - r1), 64'd35);
        run_div("s_7_m2", 1'b1, 32'd7, -32'sd2);
        run_div("u_fff9_2", 1'b0, 32'hFFFFFFF9, 32'd2);
        run_div("s_min_m1", 1'b1, 32'h80000000, 32'hFFFFFFFF);
        run_div("u_max_max", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_div("zero_u", 1'b0, 32'd1234, 32'd0);
        run_div("zero_s", 1'b1, 32'h80000000, 32'd0);
        run_abort("annul10", 1'b0, 10);
        run_div("after_annul", 1'b0, 32'd9, 32'd3);
        run_abort("rst20", 1'b1, 20);
        run_div("after_rst", 1'b0, 32'd9, 32'd3);
        for (int i = 0; i < 24; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = (i % 3 == 0) ? 32'($urandom_range(1, 15)) : (i % 8 == 5) ? 32'd0 : $urandom >> $urandom_range(0, 31);
            if (i % 4 == 1) a = a | 32'h80000000;
            if (i % 5 == 2) b = -b;
            r1 = last_rise;
            run_div($sformatf("rnd%0d", i), 1'(i % 2), a, b);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
